// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : mem_pkg                                                        |
// | Purpose   : Shared types and constants for the mem_resp memory responder:  |
// |             default depth, byte-address width helper, halfword type and    |
// |             the program-loader state encoding.                             |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package mem_pkg;

  localparam int MEM_DEPTH_DEF = 2**12;

  // Byte-address width needed to cover depth halfwords.
  function automatic int addr_width(input int depth);
    return $clog2(depth * 2);
  endfunction

  // Element [0] is the even (lane 0) byte, element [1] the odd (lane 1) byte.
  typedef logic [0:1][7:0] halfword_t;

  // The count high byte is captured on the IDLE transfer, so it has no
  // state of its own.
  typedef enum logic [2:0] {
    LD_IDLE   = 3'd0,
    LD_LEN_LO = 3'd1,
    LD_DATA0  = 3'd2,
    LD_DATA1  = 3'd3,
    LD_DONE   = 3'd4
  } ld_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_resp_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : mem_resp_if                                                    |
// | Purpose   : CPU-side halfword memory bus.                                  |
// | Signals   : i_mem_di     write data (lane 0 even byte, lane 1 odd byte)    |
// |             i_mem_addr   byte address, bit 0 ignored                       |
// |             i_mem_en     access enable                                     |
// |             i_mem_rd_en  read request                                      |
// |             i_mem_wr_en  per-lane write enable                             |
// |             o_mem_do     registered read data                              |
// | Modports  : master (CPU side), slave (memory responder)                    |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface mem_resp_if #(
  parameter int MEM_DEPTH = mem_pkg::MEM_DEPTH_DEF
);
  import mem_pkg::*;

  localparam int ADDR_WIDTH = addr_width(MEM_DEPTH);

  halfword_t             i_mem_di;
  logic [ADDR_WIDTH-1:0] i_mem_addr;
  logic                  i_mem_en;
  logic                  i_mem_rd_en;
  logic [0:1]            i_mem_wr_en;
  halfword_t             o_mem_do;

  modport master (
    output i_mem_di, i_mem_addr, i_mem_en, i_mem_rd_en, i_mem_wr_en,
    input  o_mem_do
  );

  modport slave (
    input  i_mem_di, i_mem_addr, i_mem_en, i_mem_rd_en, i_mem_wr_en,
    output o_mem_do
  );

endinterface
`default_nettype wire

// File: rtl/mem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : mem_loader                                                     |
// | Purpose   : Byte-serial program loader. Accepts a 2-byte big-endian count  |
// |             N followed by N halfwords (lane 0 byte, then lane 1 byte) and  |
// |             emits full-halfword writes to indices 0..N-1 while holding     |
// |             the CPU in reset.                                              |
// | Ports     : clk, rst (async, active low)                                   |
// |             i_ld_valid / i_ld_byte / o_ld_ready : byte stream handshake    |
// |             o_cpu_hold  : high from count-low phase through DONE           |
// |             o_ld_done   : one-cycle pulse in DONE                          |
// |             o_wr_stb / o_wr_idx / o_wr_data : RAM write request            |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module mem_loader
  import mem_pkg::*;
#(
  parameter int IDX_WIDTH = addr_width(MEM_DEPTH_DEF) - 1
) (
  input  wire                  clk,
  input  wire                  rst,
  input  wire                  i_ld_valid,
  input  wire  [7:0]           i_ld_byte,
  output logic                 o_ld_ready,
  output logic                 o_cpu_hold,
  output logic                 o_ld_done,
  output logic                 o_wr_stb,
  output logic [IDX_WIDTH-1:0] o_wr_idx,
  output halfword_t            o_wr_data
);

  ld_state_t            r_state;
  ld_state_t            w_state_nxt;
  logic [15:0]          r_remain;
  logic [IDX_WIDTH-1:0] r_ptr;
  logic [7:0]           r_lane0;
  logic                 w_accept;

  assign o_ld_ready = (r_state != LD_DONE);
  assign w_accept   = i_ld_valid & o_ld_ready;

  // The halfword is written on the lane-1 transfer itself, so the data
  // combines the latched lane-0 byte with the live input byte.
  assign o_wr_idx  = r_ptr;
  assign o_wr_data = {r_lane0, i_ld_byte};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= LD_IDLE;
      r_remain <= '0;
      r_ptr    <= '0;
      r_lane0  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        case (r_state)
          LD_IDLE: begin
            r_remain <= {i_ld_byte, 8'h00};
            r_ptr    <= '0;
          end
          LD_LEN_LO: r_remain[7:0] <= i_ld_byte;
          LD_DATA0:  r_lane0       <= i_ld_byte;
          LD_DATA1: begin
            r_remain <= r_remain - 16'd1;
            r_ptr    <= r_ptr + 1'b1;  // wraps modulo depth
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_cpu_hold  = 1'b1;
    o_ld_done   = 1'b0;
    o_wr_stb    = 1'b0;
    case (r_state)
      LD_IDLE: begin
        o_cpu_hold = 1'b0;
        if (w_accept) w_state_nxt = LD_LEN_LO;
      end
      LD_LEN_LO: begin
        if (w_accept)
          w_state_nxt = ({r_remain[15:8], i_ld_byte} == 16'd0) ? LD_DONE : LD_DATA0;
      end
      LD_DATA0: begin
        if (w_accept) w_state_nxt = LD_DATA1;
      end
      LD_DATA1: begin
        if (w_accept) begin
          o_wr_stb    = 1'b1;
          w_state_nxt = (r_remain == 16'd1) ? LD_DONE : LD_DATA0;
        end
      end
      LD_DONE: begin
        o_ld_done   = 1'b1;
        w_state_nxt = LD_IDLE;
      end
      default: w_state_nxt = LD_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_resp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : mem_resp                                                       |
// | Purpose   : Responder end of the CPU halfword memory interface. MEM_DEPTH  |
// |             halfwords of synchronous RAM, 1-cycle read-first reads,        |
// |             byte-lane writes, optional byte-serial program loader.         |
// | Ports     : clk, rst (async, active low)                                   |
// |             bus        : mem_resp_if.slave CPU memory port                 |
// |             i_ld_valid, i_ld_byte, o_ld_ready : loader byte stream         |
// |             o_cpu_hold : keep CPU in reset while loading                   |
// |             o_ld_done  : pulse after the last halfword is written          |
// | Config    : MEM_RESP_LOADER_EN enables the loader; when undefined the      |
// |             loader inputs are ignored and its outputs are tied low.        |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module mem_resp
  import mem_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  wire        clk,
  input  wire        rst,
  mem_resp_if.slave  bus,
  input  wire        i_ld_valid,
  input  wire  [7:0] i_ld_byte,
  output logic       o_ld_ready,
  output logic       o_cpu_hold,
  output logic       o_ld_done
);

  localparam int ADDR_WIDTH = addr_width(MEM_DEPTH);
  localparam int IDX_WIDTH  = ADDR_WIDTH - 1;

  halfword_t            r_ram [MEM_DEPTH];
  halfword_t            r_mem_do;
  logic [IDX_WIDTH-1:0] w_cpu_idx;
  logic [IDX_WIDTH-1:0] w_ld_idx;
  logic [IDX_WIDTH-1:0] w_wr_idx;
  halfword_t            w_ld_data;
  halfword_t            w_wr_data;
  logic [0:1]           w_wr_lane;
  logic                 w_ld_stb;
  logic                 w_hold;
  logic                 w_cpu_act;

  wire w_unused_addr0 = bus.i_mem_addr[0];

  assign w_cpu_idx = bus.i_mem_addr[ADDR_WIDTH-1:1];
  assign w_cpu_act = bus.i_mem_en & ~w_hold;

`ifdef MEM_RESP_LOADER_EN
  mem_loader #(
    .IDX_WIDTH (IDX_WIDTH)
  ) u_loader (
    .clk        (clk),
    .rst        (rst),
    .i_ld_valid (i_ld_valid),
    .i_ld_byte  (i_ld_byte),
    .o_ld_ready (o_ld_ready),
    .o_cpu_hold (w_hold),
    .o_ld_done  (o_ld_done),
    .o_wr_stb   (w_ld_stb),
    .o_wr_idx   (w_ld_idx),
    .o_wr_data  (w_ld_data)
  );
`else
  wire w_unused_ld = &{1'b0, i_ld_valid, i_ld_byte};

  assign o_ld_ready = 1'b0;
  assign o_ld_done  = 1'b0;
  assign w_hold     = 1'b0;
  assign w_ld_stb   = 1'b0;
  assign w_ld_idx   = '0;
  assign w_ld_data  = '0;
`endif

  assign o_cpu_hold = w_hold;

  // Single RAM write port. The loader only writes while the CPU is held,
  // so giving it priority never drops a legal CPU write.
  always_comb begin
    w_wr_idx  = w_cpu_idx;
    w_wr_data = bus.i_mem_di;
    w_wr_lane = 2'b00;
    if (w_ld_stb) begin
      w_wr_idx  = w_ld_idx;
      w_wr_data = w_ld_data;
      w_wr_lane = 2'b11;
    end else if (w_cpu_act) begin
      w_wr_lane = bus.i_mem_wr_en;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (w_wr_lane[k]) r_ram[w_wr_idx][k] <= w_wr_data[k];
    end
  end

  // Read samples the array before this edge's write lands: read-first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_do <= '0;
    end else if (w_cpu_act & bus.i_mem_rd_en) begin
      r_mem_do <= r_ram[w_cpu_idx];
    end
  end

  assign bus.o_mem_do = r_mem_do;

endmodule
`default_nettype wire

// File: doc/mem_resp.md
# mem_resp

Responder end of the CPU's halfword memory interface. Owns MEM_DEPTH halfwords of synchronous RAM, serves CPU reads with one-cycle latency and byte-lane writes, and includes a byte-serial program loader that fills memory while holding the CPU in reset. Sits between the `cpu` memory port and the board-level boot source.

## Interface
- MEM_DEPTH, 2**12, number of 16-bit halfwords stored
- ADDR_WIDTH, $clog2(MEM_DEPTH*2), byte-address width (derived localparam, not overridable)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- i_mem_di  in  [0:1][7:0]  write data; lane 0 = even byte, lane 1 = odd byte
- i_mem_addr  in  ADDR_WIDTH  byte address; bit 0 ignored
- i_mem_en  in  1  access enable; no effect when low
- i_mem_rd_en  in  1  read request (qualified by i_mem_en)
- i_mem_wr_en  in  [0:1]  per-lane write enable (qualified by i_mem_en)
- o_mem_do  out  [0:1][7:0]  registered read data
- i_ld_valid  in  1  loader byte valid
- i_ld_byte  in  8  loader byte
- o_ld_ready  out  1  loader accepts byte this cycle
- o_cpu_hold  out  1  keep CPU in reset; high while loading
- o_ld_done  out  1  one-cycle pulse after last halfword written

## Operation
- Halfword index = i_mem_addr[ADDR_WIDTH-1:1].
- CPU read: i_mem_en & i_mem_rd_en -> o_mem_do updated next edge; otherwise o_mem_do holds previous value.
- CPU write: i_mem_en & i_mem_wr_en[k] writes lane k only; other lane unchanged.
- Read and write to same index in same cycle: read returns old contents (read-first).
- While o_cpu_hold is high, all CPU-side accesses are ignored (no write, o_mem_do held).
- Loader stream: 2-byte big-endian count N, then N halfwords, each lane 0 byte then lane 1 byte, written to halfword indices 0..N-1.
- Loader FSM: IDLE -> LEN_HI -> LEN_LO -> DATA0 -> DATA1 -> (DATA0 | DONE) -> IDLE.
  - IDLE: o_ld_ready=1, o_cpu_hold=0; first accepted byte is the count high byte, go to LEN_LO with o_cpu_hold=1 (LEN_HI is the capture action of that transfer).
  - LEN_LO: capture low byte; N=0 -> DONE, else DATA0.
  - DATA0: latch lane-0 byte. DATA1: on accept, write full halfword {lane0, byte} at index ptr, ptr++, decrement remaining; remaining reaches 0 -> DONE.
  - DONE: one cycle, o_ld_done=1, o_cpu_hold=1; -> IDLE.
- Byte accepted only when i_ld_valid & o_ld_ready; o_ld_ready=1 in IDLE, LEN_LO, DATA0, DATA1, 0 in DONE.
- Index pointer is ADDR_WIDTH-1 bits; N > MEM_DEPTH wraps modulo MEM_DEPTH (later writes overwrite).

## Timing
- Reset values: o_mem_do=0, o_ld_ready=1 (IDLE), o_cpu_hold=0, o_ld_done=0, FSM=IDLE, ptr=0. RAM contents not reset.
- Read latency exactly 1 cycle; back-to-back reads every cycle.
- Loader write lands in RAM on the edge accepting the lane-1 byte; readable by CPU after hold deasserts.
- o_cpu_hold rises the cycle after the count high byte is accepted; falls the cycle after DONE (i.e. with IDLE).
- i_ld_valid gaps allowed in any state; FSM waits.
- Reset asserted mid-load: FSM to IDLE immediately, hold drops, already-written halfwords remain.

## Configuration
- MEM_RESP_LOADER_EN defined: loader FSM and ports active as above.
- Undefined: loader logic absent; i_ld_* ignored, o_ld_ready=0, o_cpu_hold=0, o_ld_done=0 constantly; CPU port always active.

## Structure
- Shared package mem_pkg: MEM_DEPTH default, ADDR_WIDTH function, halfword typedef `logic [0:1][7:0]`, loader state enum.
- One sub-module: mem_loader (FSM, count, pointer, lane-0 latch; outputs write index/data/strobe and hold). Top muxes loader vs CPU write onto single RAM write port.

## Test plan
- Reset, then write 0xAB to addr 0x0004 lane 0 only, read 0x0004 -> o_mem_do = {0xAB, old lane 1}, one cycle after read.
- Write {0x12,0x34} to 0x0010 and read 0x0010 same cycle -> old value; read next cycle -> {0x12,0x34}.
- Loader stream 00 02 DE AD BE EF -> o_cpu_hold high through load, o_ld_done pulse, then reads of 0x0000/0x0002 return DEAD/BEEF.
- Loader count 00 00 -> DONE directly, no RAM change, hold high exactly 2 cycles.
- CPU write to 0x0000 while o_cpu_hold high -> ignored; loaded value survives.
- Reset after 1 of 3 halfwords loaded -> hold=0, FSM IDLE, index 0 holds loaded value; MEM_RESP_LOADER_EN undefined -> o_ld_ready stays 0.
